link_ctrl: RTL and testbench

//  Sequences the 162-bit board-link between the two boards: decides when tx fires and with what data,

---
 rtl/link_ctrl_pkg.sv | 26 ++
 rtl/link_ctrl_if.sv | 31 +++
 rtl/link_ctrl_timer.sv | 42 ++++
 rtl/link_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_link_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_ctrl_pkg.sv
// Shared types and constants for the inter-board link: frame width, cell codes and link states.
package link_ctrl_pkg;

  localparam int unsigned BOARD_W = 162;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 2;

  typedef logic [BOARD_W-1:0] board_t;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_BLACK = 2'b01,
    CELL_WHITE = 2'b10
  } cell_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_ECHO     = 3'd4,
    ST_ECHO_TX  = 3'd5,
    ST_ERR      = 3'd6
  } link_state_t;

endpackage

// File: rtl/link_ctrl_if.sv
// Board-link bundle between link_ctrl (slave) and its game/tx/rx surroundings (master).
interface link_ctrl_if;
  import link_ctrl_pkg::*;

  logic               move_commit_in;
  board_t             board_in;
  logic               resend_btn_in;
  logic               tx_trigger_out;
  board_t             tx_data_out;
  logic               tx_busy_in;
  logic               rx_ready_in;
  board_t             rx_data_in;
  board_t             peer_board_out;
  logic               peer_valid_out;
  logic               link_err_out;
  logic [RETRY_W-1:0] retry_cnt_out;
  logic [STATE_W-1:0] state_out;

  modport slave (
    input  move_commit_in, board_in, resend_btn_in, tx_busy_in, rx_ready_in, rx_data_in,
    output tx_trigger_out, tx_data_out, peer_board_out, peer_valid_out, link_err_out,
           retry_cnt_out, state_out
  );

  modport master (
    output move_commit_in, board_in, resend_btn_in, tx_busy_in, rx_ready_in, rx_data_in,
    input  tx_trigger_out, tx_data_out, peer_board_out, peer_valid_out, link_err_out,
           retry_cnt_out, state_out
  );

endinterface

// File: rtl/link_ctrl_timer.sv
// Saturating cycle counter with synchronous clear; expire_o flags count == TIMEOUT_CYCLES-1.
module link_ctrl_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expire_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign count_o  = cnt_q;
  assign expire_o = expire_q;

endmodule

// File: rtl/link_ctrl.sv
// Board-link sequencer: arbitrates tx between local commits, peer echoes and manual resend,
// waits for the peer's echo-ack with timeout/retry, and delivers peer boards upstream.
module link_ctrl
  import link_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TX_MIN_CYC     = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  link_ctrl_if.slave   bus_io
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  link_state_t        state_q, state_d;
  board_t             last_sent_q, last_sent_d;
  board_t             pend_board_q, pend_board_d;
  logic               pend_commit_q, pend_commit_d;
  board_t             rx_hold_q, rx_hold_d;
  logic               rx_pend_q, rx_pend_d;
  logic               btn_q;
  logic               tx_trigger_q, tx_trigger_d;
  board_t             tx_data_q, tx_data_d;
  board_t             peer_board_q, peer_board_d;
  logic               peer_valid_q, peer_valid_d;
  logic               link_err_q, link_err_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  logic             resend_edge;
  logic             tx_done;
  logic             deliver, rx_ack, take_live, take_pend;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expire;

  // Timer restarts on every state change, so it measures time spent in the current state.
  link_ctrl_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_i  (state_d != state_q),
    .enable_i (1'b1),
    .count_o  (tmr_count),
    .expire_o (tmr_expire)
  );

  assign resend_edge = bus_io.resend_btn_in & ~btn_q;
  // tx_busy_in is ignored until tx has had time to raise it after the trigger.
  assign tx_done     = (tmr_count >= CNT_W'(TX_MIN_CYC - 1)) && !bus_io.tx_busy_in;

  always_comb begin
    state_d       = state_q;
    last_sent_d   = last_sent_q;
    pend_board_d  = pend_board_q;
    pend_commit_d = pend_commit_q;
    rx_hold_d     = rx_hold_q;
    rx_pend_d     = rx_pend_q;
    tx_trigger_d  = 1'b0;
    tx_data_d     = tx_data_q;
    peer_board_d  = peer_board_q;
    peer_valid_d  = 1'b0;
    link_err_d    = link_err_q;
    retry_d       = retry_q;
    deliver       = 1'b0;
    rx_ack        = 1'b0;
    take_live     = 1'b0;
    take_pend     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A frame arriving this very cycle outranks a commit; handle it once captured.
        if (rx_pend_q) begin
          deliver = 1'b1;
          state_d = ST_ECHO;
        end else if (bus_io.rx_ready_in) begin
          state_d = ST_IDLE;
        end else if (pend_commit_q) begin
          take_pend   = 1'b1;
          last_sent_d = pend_board_q;
          retry_d     = '0;
          state_d     = ST_SEND;
        end else if (bus_io.move_commit_in) begin
          take_live   = 1'b1;
          last_sent_d = bus_io.board_in;
          retry_d     = '0;
          state_d     = ST_SEND;
        end else if (resend_edge) begin
          retry_d = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data_d    = last_sent_q;
        tx_trigger_d = 1'b1;
        state_d      = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (rx_pend_q && (rx_hold_q == last_sent_q)) begin
          rx_ack  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          deliver = rx_pend_q;
          if (tmr_expire) begin
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_SEND;
            end else begin
              link_err_d = 1'b1;
              state_d    = ST_ERR;
            end
          end
        end
      end
      ST_ECHO: begin
        tx_data_d    = peer_board_q;
        tx_trigger_d = 1'b1;
        state_d      = ST_ECHO_TX;
      end
      ST_ECHO_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      ST_ERR: begin
        deliver = rx_pend_q;
        if (resend_edge) begin
          link_err_d = 1'b0;
          retry_d    = '0;
          state_d    = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (deliver) begin
      peer_board_d = rx_hold_q;
      peer_valid_d = 1'b1;
    end
    if (deliver || rx_ack) rx_pend_d = 1'b0;
    // New capture wins over the clear of an older frame handled this cycle.
    if (bus_io.rx_ready_in) begin
      rx_hold_d = bus_io.rx_data_in;
      rx_pend_d = 1'b1;
    end

    if (take_pend) pend_commit_d = 1'b0;
    if (bus_io.move_commit_in && !take_live) begin
      pend_commit_d = 1'b1;
      pend_board_d  = bus_io.board_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      last_sent_q   <= '0;
      pend_board_q  <= '0;
      pend_commit_q <= 1'b0;
      rx_hold_q     <= '0;
      rx_pend_q     <= 1'b0;
      btn_q         <= 1'b0;
      tx_trigger_q  <= 1'b0;
      tx_data_q     <= '0;
      peer_board_q  <= '0;
      peer_valid_q  <= 1'b0;
      link_err_q    <= 1'b0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_sent_q   <= last_sent_d;
      pend_board_q  <= pend_board_d;
      pend_commit_q <= pend_commit_d;
      rx_hold_q     <= rx_hold_d;
      rx_pend_q     <= rx_pend_d;
      btn_q         <= bus_io.resend_btn_in;
      tx_trigger_q  <= tx_trigger_d;
      tx_data_q     <= tx_data_d;
      peer_board_q  <= peer_board_d;
      peer_valid_q  <= peer_valid_d;
      link_err_q    <= link_err_d;
      retry_q       <= retry_d;
    end
  end

  assign bus_io.tx_trigger_out = tx_trigger_q;
  assign bus_io.tx_data_out    = tx_data_q;
  assign bus_io.peer_board_out = peer_board_q;
  assign bus_io.peer_valid_out = peer_valid_q;
  assign bus_io.link_err_out   = link_err_q;
  assign bus_io.retry_cnt_out  = retry_q;
  assign bus_io.state_out      = state_q;

endmodule

// File: tb/tb_link_ctrl.sv
// Self-checking bench for link_ctrl: tx busy model, trigger/peer-delivery monitors and
// per-scenario tasks checking against frame-level expectations.
module tb_link_ctrl;
  import link_ctrl_pkg::*;

  localparam int unsigned TO      = 100;
  localparam int unsigned TX_BUSY = 170;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_ctrl_if u_if ();

  link_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus_io (u_if)
  );

  // tx stand-in: busy for TX_BUSY cycles after each trigger
  int busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (u_if.tx_trigger_out) busy_cnt <= TX_BUSY;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign u_if.tx_busy_in = (busy_cnt != 0);

  board_t trig_data[$];
  int     trig_time[$];
  board_t pv_data[$];
  int     cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (u_if.tx_trigger_out === 1'b1) begin
      trig_data.push_back(u_if.tx_data_out);
      trig_time.push_back(cyc);
    end
    if (u_if.peer_valid_out === 1'b1) pv_data.push_back(u_if.peer_board_out);
  end

  int errors = 0;
  int checks = 0;

  function automatic board_t rand_board();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[BOARD_W-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    trig_data.delete();
    trig_time.delete();
    pv_data.delete();
  endtask

  task automatic pulse_commit(input board_t b);
    u_if.board_in       = b;
    u_if.move_commit_in = 1'b1;
    tick(1);
    u_if.move_commit_in = 1'b0;
  endtask

  task automatic pulse_rx(input board_t b);
    u_if.rx_data_in  = b;
    u_if.rx_ready_in = 1'b1;
    tick(1);
    u_if.rx_ready_in = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (u_if.state_out == 3'(s)) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_trig(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trig_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    u_if.move_commit_in = 1'b0;
    u_if.board_in       = '0;
    u_if.resend_btn_in  = 1'b0;
    u_if.rx_ready_in    = 1'b0;
    u_if.rx_data_in     = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (u_if.state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", u_if.state_out); end
    checks++; if (u_if.tx_trigger_out !== 1'b0) begin errors++; $display("FAIL reset_trigger: got %b want 0", u_if.tx_trigger_out); end
    checks++; if (u_if.link_err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", u_if.link_err_out); end
    checks++; if (u_if.retry_cnt_out !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", u_if.retry_cnt_out); end
    checks++; if (u_if.peer_valid_out !== 1'b0) begin errors++; $display("FAIL reset_peer_valid: got %b want 0", u_if.peer_valid_out); end
    checks++; if (u_if.peer_board_out !== '0) begin errors++; $display("FAIL reset_peer_board: got %h want 0", u_if.peer_board_out); end
    checks++; if (u_if.tx_data_out !== '0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", u_if.tx_data_out); end
    #1;
  endtask

  task automatic test_reset_midframe();
    pulse_commit(rand_board());
    tick(5);
    rst = 1'b1;
    #1;
    checks++; if (u_if.state_out !== 3'd0) begin errors++; $display("FAIL midframe_state: got %0d want 0", u_if.state_out); end
    checks++; if (u_if.tx_data_out !== '0) begin errors++; $display("FAIL midframe_tx_data: got %h want 0", u_if.tx_data_out); end
    tick(2);
    rst = 1'b0;
    tick(2);
    checks++; if (u_if.state_out !== 3'd0) begin errors++; $display("FAIL midframe_no_resume: got %0d want 0", u_if.state_out); end
  endtask

  task automatic test_commit_ack(input board_t b, input int jitter);
    bit ok;
    board_t got;
    clear_mon();
    pulse_commit(b);
    wait_trig(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL commit_trigger: got none want 1 trigger"); end
    got = (trig_data.size() > 0) ? trig_data[0] : 'x;
    checks++; if (got !== b) begin errors++; $display("FAIL commit_tx_data: got %h want %h", got, b); end
    tick(180 + jitter);
    checks++; if (u_if.state_out !== 3'd3) begin errors++; $display("FAIL commit_wait_ack: got %0d want 3", u_if.state_out); end
    pulse_rx(b);
    wait_state(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL commit_ack_idle: got state %0d want 0", u_if.state_out); end
    checks++; if (u_if.link_err_out !== 1'b0 || u_if.retry_cnt_out !== 2'd0) begin errors++; $display("FAIL commit_ack_status: got err=%b retry=%0d want err=0 retry=0", u_if.link_err_out, u_if.retry_cnt_out); end
    checks++; if (trig_data.size() != 1 || pv_data.size() != 0) begin errors++; $display("FAIL commit_ack_counts: got trig=%0d pv=%0d want trig=1 pv=0", trig_data.size(), pv_data.size()); end
  endtask

  task automatic test_retry_err(input board_t b);
    bit ok;
    int gap;
    clear_mon();
    pulse_commit(b);
    wait_state(6, 1500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_reach_err: got state %0d want 6", u_if.state_out); end
    checks++; if (trig_data.size() != 4) begin errors++; $display("FAIL retry_trigger_count: got %0d want 4", trig_data.size()); end
    for (int i = 0; i < trig_data.size(); i++) begin
      checks++; if (trig_data[i] !== b) begin errors++; $display("FAIL retry_tx_data[%0d]: got %h want %h", i, trig_data[i], b); end
    end
    for (int i = 1; i < trig_time.size(); i++) begin
      gap = trig_time[i] - trig_time[i-1];
      checks++; if (gap < int'(TO + TX_BUSY) || gap > int'(TO + TX_BUSY + 10)) begin errors++; $display("FAIL retry_gap[%0d]: got %0d want about %0d", i, gap, TO + TX_BUSY + 2); end
    end
    checks++; if (u_if.link_err_out !== 1'b1) begin errors++; $display("FAIL retry_link_err: got %b want 1", u_if.link_err_out); end
    checks++; if (u_if.retry_cnt_out !== 2'd3) begin errors++; $display("FAIL retry_cnt: got %0d want 3", u_if.retry_cnt_out); end
  endtask

  task automatic test_resend_recover(input board_t b);
    bit ok;
    board_t got;
    clear_mon();
    u_if.resend_btn_in = 1'b1;
    wait_trig(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL resend_trigger: got none want 1 trigger"); end
    checks++; if (u_if.link_err_out !== 1'b0) begin errors++; $display("FAIL resend_err_clear: got %b want 0", u_if.link_err_out); end
    got = (trig_data.size() > 0) ? trig_data[0] : 'x;
    checks++; if (got !== b) begin errors++; $display("FAIL resend_tx_data: got %h want %h", got, b); end
    tick(200);
    pulse_rx(b);
    wait_state(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL resend_idle: got state %0d want 0", u_if.state_out); end
    tick(5);
    checks++; if (trig_data.size() != 1) begin errors++; $display("FAIL resend_level_once: got %0d triggers want 1", trig_data.size()); end
    u_if.resend_btn_in = 1'b0;
    tick(2);
  endtask

  task automatic test_rx_idle(input board_t r);
    bit ok;
    board_t got;
    clear_mon();
    pulse_rx(r);
    wait_trig(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rx_echo_trigger: got none want 1 trigger"); end
    got = (pv_data.size() == 1) ? pv_data[0] : 'x;
    checks++; if (got !== r) begin errors++; $display("FAIL rx_peer_valid: got %h (n=%0d) want %h", got, pv_data.size(), r); end
    checks++; if (u_if.peer_board_out !== r) begin errors++; $display("FAIL rx_peer_board: got %h want %h", u_if.peer_board_out, r); end
    got = (trig_data.size() > 0) ? trig_data[0] : 'x;
    checks++; if (got !== r) begin errors++; $display("FAIL rx_echo_data: got %h want %h", got, r); end
    wait_state(0, 400, ok);
    checks++; if (!ok || trig_data.size() != 1) begin errors++; $display("FAIL rx_echo_done: got state %0d trig=%0d want 0 and 1", u_if.state_out, trig_data.size()); end
  endtask

  task automatic test_back_to_back(input board_t r, input board_t c);
    bit ok;
    board_t g0, g1;
    clear_mon();
    u_if.rx_data_in     = r;
    u_if.board_in       = c;
    u_if.rx_ready_in    = 1'b1;
    u_if.move_commit_in = 1'b1;
    tick(1);
    u_if.rx_ready_in    = 1'b0;
    u_if.move_commit_in = 1'b0;
    wait_trig(2, 600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_two_triggers: got %0d want 2", trig_data.size()); end
    g0 = (trig_data.size() > 0) ? trig_data[0] : 'x;
    g1 = (trig_data.size() > 1) ? trig_data[1] : 'x;
    checks++; if (g0 !== r) begin errors++; $display("FAIL b2b_echo_first: got %h want %h", g0, r); end
    checks++; if (g1 !== c) begin errors++; $display("FAIL b2b_commit_second: got %h want %h", g1, c); end
    tick(190);
    pulse_rx(c);
    wait_state(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: got state %0d want 0", u_if.state_out); end
    checks++; if (pv_data.size() != 1) begin errors++; $display("FAIL b2b_pv_count: got %0d want 1", pv_data.size()); end
  endtask

  task automatic test_mismatch(input board_t c);
    bit ok;
    board_t m, got;
    m = ~c;
    clear_mon();
    pulse_commit(c);
    wait_trig(1, 20, ok);
    tick(190);
    pulse_rx(m);
    tick(3);
    got = (pv_data.size() == 1) ? pv_data[0] : 'x;
    checks++; if (got !== m) begin errors++; $display("FAIL mismatch_deliver: got %h (n=%0d) want %h", got, pv_data.size(), m); end
    tick(10);
    checks++; if (trig_data.size() != 1) begin errors++; $display("FAIL mismatch_no_echo: got %0d triggers want 1", trig_data.size()); end
    checks++; if (u_if.state_out !== 3'd3) begin errors++; $display("FAIL mismatch_still_waiting: got %0d want 3", u_if.state_out); end
    pulse_rx(c);
    wait_state(0, 20, ok);
    checks++; if (!ok || u_if.retry_cnt_out !== 2'd0) begin errors++; $display("FAIL mismatch_ack: got state %0d retry %0d want 0 0", u_if.state_out, u_if.retry_cnt_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 0) test_commit_ack(rand_board(), int'($urandom_range(0, 60)));
      else test_rx_idle(rand_board());
    end
  endtask

  initial begin
    board_t b;
    test_reset();
    test_reset_midframe();
    test_commit_ack(board_t'(1), 15);
    b = rand_board();
    test_retry_err(b);
    test_resend_recover(b);
    test_rx_idle(board_t'(5));
    test_back_to_back(rand_board(), rand_board());
    test_mismatch(board_t'(9) ^ rand_board());
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
